// File: rtl/ysyx_23060332_ifu_if.sv
// IFU bus bundle: EXU redirect, instruction-memory request/response, IDU handoff.
// misalign_o exists only when YSYX_23060332_IFU_MISALIGN_EN is defined.
interface ysyx_23060332_ifu_if;
   localparam int unsigned XLEN = 32;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst_o;
   logic [XLEN-1:0] inst_addr_o;
`ifdef YSYX_23060332_IFU_MISALIGN_EN
   logic            misalign_o;
`endif

   // IFU side
   modport master (
`ifdef YSYX_23060332_IFU_MISALIGN_EN
      output misalign_o,
`endif
      input  redirect_valid, redirect_pc,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_data,
      output inst_valid, inst_o, inst_addr_o,
      input  inst_ready
   );

   // Memory / EXU / IDU side
   modport slave (
`ifdef YSYX_23060332_IFU_MISALIGN_EN
      input  misalign_o,
`endif
      output redirect_valid, redirect_pc,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_data,
      input  inst_valid, inst_o, inst_addr_o,
      output inst_ready
   );
endinterface

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM with redirect handling.
// Optional feature: define YSYX_23060332_IFU_MISALIGN_EN to trap misaligned
// redirects in a sticky ERR state; otherwise redirect_pc[1:0] is forced to zero.
module ysyx_23060332_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input logic                 clk,
   input logic                 rst_n,
   ysyx_23060332_ifu_if.master bus
);
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
`ifdef YSYX_23060332_IFU_MISALIGN_EN
      , S_ERR
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_addr_q, inst_addr_d;
   logic            req_valid_q, req_valid_d;
   logic            inst_valid_q, inst_valid_d;
   logic [XLEN-1:0] target;
   logic            accept;
   logic            resp;

   // The request only counts once the registered valid is actually up.
   assign accept = req_valid_q && bus.imem_req_ready;
   assign resp   = bus.imem_resp_valid;

`ifdef YSYX_23060332_IFU_MISALIGN_EN
   logic misalign_q, misalign_d;
   logic bad_align;
   assign target         = bus.redirect_pc;
   assign bad_align      = bus.redirect_pc[1:0] != 2'b00;
   assign bus.misalign_o = misalign_q;
`else
   logic unused_align;
   assign target       = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_align = ^bus.redirect_pc[1:0];
`endif

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = inst_valid_q;
   assign bus.inst_o         = inst_q;
   assign bus.inst_addr_o    = inst_addr_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_REQ;
      else        state_q <= state_d;
   end

   // Next-state logic; a redirect always wins over normal progress
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_REQ: begin
            if (bus.redirect_valid) state_d = accept ? S_DROP : S_REQ;
            else if (accept)        state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.redirect_valid) state_d = resp ? S_REQ : S_DROP;
            else if (resp)          state_d = S_HOLD;
         end
         S_HOLD: begin
            if (bus.redirect_valid || bus.inst_ready) state_d = S_REQ;
         end
         S_DROP: begin
            if (resp) state_d = S_REQ;
         end
         default: state_d = state_q;
      endcase
`ifdef YSYX_23060332_IFU_MISALIGN_EN
      if (bus.redirect_valid && bad_align) state_d = S_ERR;
`endif
   end

   // Output / datapath next values
   always_comb begin
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_addr_d  = inst_addr_q;
      req_valid_d  = state_d == S_REQ;
      inst_valid_d = state_d == S_HOLD;
`ifdef YSYX_23060332_IFU_MISALIGN_EN
      misalign_d   = state_d == S_ERR;
`endif
      if (bus.redirect_valid)
         pc_d = target;
      else if (state_q == S_HOLD && bus.inst_ready)
         pc_d = pc_q + XLEN'(4);
      if (state_q == S_WAIT && resp && !bus.redirect_valid) begin
         inst_d      = bus.imem_resp_data;
         inst_addr_d = pc_q;
      end
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         inst_q       <= NOP;
         inst_addr_q  <= '0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
`ifdef YSYX_23060332_IFU_MISALIGN_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_addr_q  <= inst_addr_d;
         req_valid_q  <= req_valid_d;
         inst_valid_q <= inst_valid_d;
`ifdef YSYX_23060332_IFU_MISALIGN_EN
         misalign_q   <= misalign_d;
`endif
      end
   end
endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for ysyx_23060332_ifu with a small instruction-memory responder.
module tb_ysyx_23060332_ifu;
   logic        clk = 1'b0;
   logic        rst_n;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          mem_delay = 0;
   logic        resp_valid = 1'b0;
   logic [31:0] resp_data  = 32'h0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          cnt = 0;

   always #5 clk = ~clk;

   ysyx_23060332_ifu_if bus();

   ysyx_23060332_ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.imem_resp_valid = resp_valid;
   assign bus.imem_resp_data  = resp_data;

   // Memory content: a fixed scramble of the address
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // Responder: mem_delay=0 answers in the cycle after acceptance
   always @(posedge clk) begin
      resp_valid <= 1'b0;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         if (mem_delay == 0) begin
            resp_valid <= 1'b1;
            resp_data  <= inst_of(bus.imem_req_addr);
            pend       <= 1'b0;
         end else begin
            pend      <= 1'b1;
            pend_addr <= bus.imem_req_addr;
            cnt       <= mem_delay - 1;
         end
      end else if (pend) begin
         if (cnt == 0) begin
            resp_valid <= 1'b1;
            resp_data  <= inst_of(pend_addr);
            pend       <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for the next inst_valid and check its address and word
   task automatic wait_inst(input string tag, input logic [31:0] exp_addr);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.inst_valid && n < 20);
      check({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
      check({tag, "_addr"}, bus.inst_addr_o, exp_addr);
      check({tag, "_data"}, bus.inst_o, inst_of(exp_addr));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.inst_ready     = 1'b1;
      bus.imem_req_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst_o, 32'h0000_0013);
      check("rst_inst_addr", bus.inst_addr_o, 32'h0);
      check("rst_pc", bus.imem_req_addr, 32'h8000_0000);
      rst_n = 1'b1;
      #1 check("release_no_change", 32'(bus.imem_req_valid), 32'd0);

      // First fetch timing, then two sequential fetches
      @(negedge clk);
      check("t036_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("t036_req_addr", bus.imem_req_addr, 32'h8000_0000);
      @(negedge clk);
      check("t036_wait_req", 32'(bus.imem_req_valid), 32'd0);
      check("t036_wait_inst", 32'(bus.inst_valid), 32'd0);
      @(negedge clk);
      check("t036_i0_valid", 32'(bus.inst_valid), 32'd1);
      check("t036_i0_addr", bus.inst_addr_o, 32'h8000_0000);
      check("t036_i0_data", bus.inst_o, inst_of(32'h8000_0000));
      wait_inst("t036_i1", 32'h8000_0004);
      wait_inst("t036_i2", 32'h8000_0008);

      // Back-pressure: hold the first instruction for 5 cycles
      bus.inst_ready = 1'b0;
      do_reset();
      wait_inst("t037_first", 32'h8000_0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t037_hold_valid", 32'(bus.inst_valid), 32'd1);
         check("t037_hold_addr", bus.inst_addr_o, 32'h8000_0000);
         check("t037_hold_data", bus.inst_o, inst_of(32'h8000_0000));
         check("t037_hold_noreq", 32'(bus.imem_req_valid), 32'd0);
      end
      bus.inst_ready = 1'b1;
      @(negedge clk);
      check("t037_rel_valid", 32'(bus.inst_valid), 32'd0);
      check("t037_rel_req", 32'(bus.imem_req_valid), 32'd1);
      check("t037_rel_addr", bus.imem_req_addr, 32'h8000_0004);
      wait_inst("t037_next", 32'h8000_0004);

      // Redirect in HOLD with inst_ready=1: no PC+4
      redirect(32'h8000_0100);
      check("t039_valid", 32'(bus.inst_valid), 32'd0);
      check("t039_req", 32'(bus.imem_req_valid), 32'd1);
      check("t039_addr", bus.imem_req_addr, 32'h8000_0100);
      wait_inst("t039", 32'h8000_0100);

      // Redirect in WAIT before the (slow) response: stale word dropped
      mem_delay = 2;
      @(negedge clk);
      @(negedge clk);
      check("t038_in_wait", 32'(bus.imem_req_valid), 32'd0);
      mem_delay = 0;
      redirect(32'h8000_0100);
      check("t038_drop_req", 32'(bus.imem_req_valid), 32'd0);
      check("t038_drop_inst", 32'(bus.inst_valid), 32'd0);
      wait_inst("t038", 32'h8000_0100);

      // Redirect in WAIT in the same cycle as the response
      @(negedge clk);
      @(negedge clk);
      check("t025_resp_now", 32'(bus.imem_resp_valid), 32'd1);
      redirect(32'h8000_0300);
      check("t025_valid", 32'(bus.inst_valid), 32'd0);
      check("t025_req", 32'(bus.imem_req_valid), 32'd1);
      check("t025_addr", bus.imem_req_addr, 32'h8000_0300);
      wait_inst("t025", 32'h8000_0300);

      // Redirect in REQ without acceptance
      bus.imem_req_ready = 1'b0;
      @(negedge clk);
      redirect(32'h8000_0400);
      check("t024a_req", 32'(bus.imem_req_valid), 32'd1);
      check("t024a_addr", bus.imem_req_addr, 32'h8000_0400);
      bus.imem_req_ready = 1'b1;
      wait_inst("t024a", 32'h8000_0400);

      // Redirect in REQ with acceptance: old response dropped
      @(negedge clk);
      redirect(32'h8000_0500);
      check("t024b_drop_req", 32'(bus.imem_req_valid), 32'd0);
      check("t024b_drop_inst", 32'(bus.inst_valid), 32'd0);
      wait_inst("t024b", 32'h8000_0500);

      // PC wrap at the top of the address space
      redirect(32'hFFFF_FFFC);
      wait_inst("t040_top", 32'hFFFF_FFFC);
      @(negedge clk);
      check("t040_wrap_req", 32'(bus.imem_req_valid), 32'd1);
      check("t040_wrap_addr", bus.imem_req_addr, 32'h0000_0000);
      wait_inst("t040_wrap", 32'h0000_0000);

`ifdef YSYX_23060332_IFU_MISALIGN_EN
      // Misaligned redirect traps until reset
      redirect(32'h8000_0102);
      for (int i = 0; i < 4; i++) begin
         check("t041_misalign", 32'(bus.misalign_o), 32'd1);
         check("t041_noreq", 32'(bus.imem_req_valid), 32'd0);
         check("t041_noinst", 32'(bus.inst_valid), 32'd0);
         @(negedge clk);
      end
      do_reset();
      check("t041_cleared", 32'(bus.misalign_o), 32'd0);
      wait_inst("t041_after", 32'h8000_0000);
`else
      // Low address bits of the target are ignored
      redirect(32'h8000_0102);
      check("t035_addr", bus.imem_req_addr, 32'h8000_0100);
      wait_inst("t035", 32'h8000_0100);
`endif

      // Reset during WAIT abandons the request; late response ignored
      mem_delay = 1;
      @(negedge clk);
      @(negedge clk);
      check("t032_in_wait", 32'(bus.imem_req_valid), 32'd0);
      mem_delay = 0;
      rst_n = 1'b0;
      #1;
      check("t032_rst_req", 32'(bus.imem_req_valid), 32'd0);
      check("t032_rst_inst", bus.inst_o, 32'h0000_0013);
      @(negedge clk);
      rst_n = 1'b1;
      wait_inst("t032", 32'h8000_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ysyx_23060332_ifu.md
YSYX_23060332_IFU -- requirements
Module: ysyx_23060332_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: address of the first fetch after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 redirect_valid  input  1  taken jump/branch from EXU; one-cycle pulse.
REQ-005 redirect_pc  input  32  jump target, sampled when redirect_valid=1.
REQ-006 imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_req_addr  output  32  fetch address; equals current PC.
REQ-009 imem_resp_valid  input  1  instruction word returned.
REQ-010 imem_resp_data  input  32  returned instruction word.
REQ-011 inst_valid  output  1  instruction available to IDU.
REQ-012 inst_ready  input  1  IDU consumes the instruction this cycle.
REQ-013 inst_o  output  32  instruction word to IDU (inst_i there).
REQ-014 inst_addr_o  output  32  PC of inst_o (inst_addr there).
REQ-015 misalign_o  output  1  misaligned redirect flag; present only under REQ-034.

Function
REQ-016 FSM states SHALL be: REQ, WAIT, HOLD, DROP (plus ERR under REQ-034).
REQ-017 REQ: imem_req_valid=1, imem_req_addr=PC; on imem_req_ready -> WAIT.
REQ-018 WAIT: on imem_resp_valid, register imem_resp_data into inst_o and PC into inst_addr_o -> HOLD.
REQ-019 HOLD: inst_valid=1; inst_o/inst_addr_o SHALL stay stable while inst_ready=0.
REQ-020 HOLD with inst_ready=1: PC <= PC+4 -> REQ; inst_valid=0 next cycle.
REQ-021 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 Latency: with req accepted in cycle N and response in cycle N+1, inst_valid SHALL be 1 in cycle N+2.
REQ-023 At most one outstanding memory request at any time.
REQ-024 Redirect in REQ without accept: PC <= redirect_pc, stay REQ; with accept same cycle: PC <= redirect_pc -> DROP.
REQ-025 Redirect in WAIT, no response: PC <= redirect_pc -> DROP; response same cycle: discard it -> REQ.
REQ-026 DROP: imem_req_valid=0, inst_valid=0; on imem_resp_valid discard data -> REQ.
REQ-027 Redirect in HOLD SHALL override inst_ready: PC <= redirect_pc, no PC+4, inst_valid=0 next cycle -> REQ.
REQ-028 Redirect-discarded instructions SHALL never reach IDU.
REQ-029 imem_resp_valid in REQ or HOLD SHALL be ignored.

Reset
REQ-030 While rst_n=0: state=REQ, PC=RESET_PC, inst_o=32'h0000_0013 (NOP), inst_addr_o=0, inst_valid=0, misalign_o=0.
REQ-031 imem_req_valid SHALL be 0 during reset and 1 the first cycle after release.
REQ-032 Reset asserted mid-WAIT SHALL abandon the request; any later response treated per REQ-029.
REQ-033 No output may change on rst_n deassertion except via next clk edge.

Configuration
REQ-034 Macro YSYX_23060332_IFU_MISALIGN_EN defined: redirect_pc[1:0]!=0 -> ERR; ERR issues no requests, inst_valid=0, misalign_o=1 until reset.
REQ-035 Macro undefined: misalign_o absent; redirect_pc[1:0] forced to 2'b00.

Verification
REQ-036 Reset release, 1-cycle memory, inst_ready=1: fetches 0x80000000, 0x80000004, 0x80000008 in order; first inst_valid 2 cycles after request.
REQ-037 inst_ready=0 for 5 cycles in HOLD: inst_o/inst_addr_o constant, no new request; ready=1 -> next PC 0x80000004.
REQ-038 Redirect to 0x80000100 while in WAIT: stale response dropped, next inst_addr_o=0x80000100.
REQ-039 Redirect with inst_ready=1 in HOLD: next fetch 0x80000100, not PC+4.
REQ-040 Redirect to 0xFFFFFFFC, inst_ready=1: following fetch address 0x00000000.
REQ-041 With macro, redirect to 0x80000102: misalign_o=1, imem_req_valid=0 until rst_n pulse.
